// File: rtl/spike_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spike_enc_pkg
// Purpose : Shared types and helpers for the spike pulse encoder: lane state
//           encoding, unary pulse width and down-counter width.
// Revision: 1.0 - initial release
// ============================================================================
package spike_enc_pkg;

    // Lane state; two bits cover the three states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIRE = 2'd2
    } lane_state_t;

    // Unary pulse width for a given weight resolution.
    function automatic int wmax(input int wres);
        return (1 << wres) - 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int TRES_DEF = 3;
    localparam int WRES_DEF = 3;
    // Counter must hold both a spike time and a pulse width.
    localparam int CNTW = max_int(TRES_DEF, WRES_DEF);

endpackage
`default_nettype wire

// File: rtl/spike_pulse_lane.sv
`default_nettype none
// ============================================================================
// Module  : spike_pulse_lane
// Purpose : One channel of the encoder. On a gamma pulse it loads a spike
//           time, waits that many cycles, then drives a pulse wmax cycles wide.
// Revision: 1.0 - initial release
// ============================================================================
module spike_pulse_lane
    import spike_enc_pkg::*;
#(
    parameter int TRES = 3,
    parameter int WRES = 3
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic            grst,
    input  logic            load,
    input  logic            mask,
    input  logic [TRES-1:0] spike_time,
    output logic            spike,
    output logic            idle,
    output logic            abort
);

    localparam int            CW        = max_int(TRES, WRES);
    localparam logic [CW-1:0] C_WMAX_M1 = CW'(wmax(WRES) - 1);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    lane_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [CW-1:0] time_ext;

    assign time_ext = CW'(spike_time);

    // Next-state: a gamma pulse always wins and reloads the lane; otherwise
    // count down through WAIT and FIRE, testing zero before decrementing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (grst) begin
            if (load && mask) begin
                if (spike_time == '0) begin
                    state_d = FIRE;
                    cnt_d   = C_WMAX_M1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = time_ext - C_ONE;
                end
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = FIRE;
                        cnt_d   = C_WMAX_M1;
                    end else begin
                        cnt_d   = cnt_q - C_ONE;
                    end
                end
                FIRE: begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = cnt_q - C_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode registered state only, so the pulse cannot glitch.
    assign spike = (state_q == FIRE);
    assign idle  = (state_q == IDLE);
    assign abort = grst && (state_q != IDLE);

endmodule
`default_nettype wire

// File: rtl/spike_pulse_encoder.sv
`default_nettype none
// ============================================================================
// Module  : spike_pulse_encoder
// Purpose : Column front end. Stages one word of per-channel spike times via
//           valid/ready and, on each gamma pulse, hands it to NCH lanes that
//           play it out as unary pulses while the next word is staged.
// Revision: 1.0 - initial release
// ============================================================================
module spike_pulse_encoder
    import spike_enc_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int TRES = 3,
    parameter int WRES = 3
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                grst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NCH-1:0]      in_mask,
    input  logic [NCH*TRES-1:0] in_times,
    output logic [NCH-1:0]      input_spike,
    output logic                all_idle,
    output logic                underrun,
    output logic                overrun
);

    logic                staged_full_q,  staged_full_d;
    logic [NCH-1:0]      staged_mask_q,  staged_mask_d;
    logic [NCH*TRES-1:0] staged_times_q, staged_times_d;
    logic                underrun_q,     underrun_d;
    logic                overrun_q,      overrun_d;

    logic                accept;
    logic [NCH-1:0]      lane_idle;
    logic [NCH-1:0]      lane_abort;

    assign in_ready = !staged_full_q;
    assign accept   = in_valid && in_ready;

    // Staging and flag next-state. A gamma pulse drains a full stage; when
    // the stage is already empty a same-edge handshake fills it for the
    // following gamma instead.
    always_comb begin
        staged_full_d  = staged_full_q;
        staged_mask_d  = staged_mask_q;
        staged_times_d = staged_times_q;
        if (grst && staged_full_q) begin
            staged_full_d = 1'b0;
        end else if (accept) begin
            staged_full_d  = 1'b1;
            staged_mask_d  = in_mask;
            staged_times_d = in_times;
        end
        underrun_d = grst && !staged_full_q;
        overrun_d  = overrun_q || (|lane_abort);
    end

    // Staging register and status flags.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            staged_full_q  <= 1'b0;
            staged_mask_q  <= '0;
            staged_times_q <= '0;
            underrun_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            staged_full_q  <= staged_full_d;
            staged_mask_q  <= staged_mask_d;
            staged_times_q <= staged_times_d;
            underrun_q     <= underrun_d;
            overrun_q      <= overrun_d;
        end
    end

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_lane
            spike_pulse_lane #(
                .TRES (TRES),
                .WRES (WRES)
            ) u_lane (
                .clk        (clk),
                .rstb       (rstb),
                .grst       (grst),
                .load       (staged_full_q),
                .mask       (staged_mask_q[c]),
                .spike_time (staged_times_q[c*TRES +: TRES]),
                .spike      (input_spike[c]),
                .idle       (lane_idle[c]),
                .abort      (lane_abort[c])
            );
        end
    endgenerate

    assign all_idle = &lane_idle;
    assign underrun = underrun_q;
    assign overrun  = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_pulse_encoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spike_pulse_encoder
// Purpose : Self-checking bench for spike_pulse_encoder (NCH=4, TRES=3,
//           WRES=3, wmax=7). Stimulus pushes per-cycle expectations into a
//           scoreboard queue; a monitor pops and compares on each falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spike_pulse_encoder;

    localparam int NCH  = 4;
    localparam int TRES = 3;
    localparam int WRES = 3;
    localparam int WMAX = 7;

    logic                clk = 1'b0;
    logic                rstb;
    logic                grst;
    logic                in_valid;
    logic                in_ready;
    logic [NCH-1:0]      in_mask;
    logic [NCH*TRES-1:0] in_times;
    logic [NCH-1:0]      input_spike;
    logic                all_idle;
    logic                underrun;
    logic                overrun;

    spike_pulse_encoder #(
        .NCH  (NCH),
        .TRES (TRES),
        .WRES (WRES)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .grst        (grst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mask     (in_mask),
        .in_times    (in_times),
        .input_spike (input_spike),
        .all_idle    (all_idle),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        logic [NCH-1:0] spk;
        logic           idle;
        logic           und;
        logic           ovr;
        logic           rdy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (gamma level, not per-lane FSM)
    logic                m_full  = 1'b0;
    logic [NCH-1:0]      m_mask  = '0;
    logic [NCH*TRES-1:0] m_times = '0;
    logic [NCH-1:0]      l_mask  = '0;
    logic [NCH*TRES-1:0] l_times = '0;
    int                  l_g     = -100;
    logic                m_und   = 1'b0;
    logic                m_ovr   = 1'b0;

    function automatic logic [NCH*TRES-1:0] pack(input int t0, input int t1,
                                                 input int t2, input int t3);
        return {3'(t3), 3'(t2), 3'(t1), 3'(t0)};
    endfunction

    // Lane c not idle at cycle n: spiking lane, between gamma+1 and t+wmax.
    function automatic logic busy(input int c, input int n);
        int k = n - l_g;
        int t = int'(l_times[c*TRES +: TRES]);
        return l_mask[c] && (k >= 1) && (k <= t + WMAX);
    endfunction

    function automatic logic firing(input int c, input int n);
        int k = n - l_g;
        int t = int'(l_times[c*TRES +: TRES]);
        return l_mask[c] && (k >= t + 1) && (k <= t + WMAX);
    endfunction

    task automatic push_exp(input int n);
        exp_t e;
        e.cyc  = n;
        e.idle = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            e.spk[c] = firing(c, n);
            if (busy(c, n)) e.idle = 1'b0;
        end
        e.und = m_und;
        e.ovr = m_ovr;
        e.rdy = !m_full;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_full = 1'b0;
        l_mask = '0;
        m_und  = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // Advance the model with the inputs of the current cycle, queue the
    // expectation for the next cycle, then step the clock.
    task automatic tick();
        int   n = cyc;
        logic any_busy = 1'b0;
        if (!rstb) begin
            model_reset();
        end else begin
            for (int c = 0; c < NCH; c++) if (busy(c, n)) any_busy = 1'b1;
            m_und = 1'b0;
            if (grst) begin
                if (any_busy) m_ovr = 1'b1;
                l_g = n;
                if (m_full) begin
                    l_mask  = m_mask;
                    l_times = m_times;
                    m_full  = 1'b0;
                end else begin
                    l_mask = '0;
                    m_und  = 1'b1;
                    if (in_valid) begin
                        m_mask  = in_mask;
                        m_times = in_times;
                        m_full  = 1'b1;
                    end
                end
            end else if (in_valid && !m_full) begin
                m_mask  = in_mask;
                m_times = in_times;
                m_full  = 1'b1;
            end
        end
        push_exp(n + 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Reset asserted between edges, held over one edge, released between edges.
    task automatic async_reset_pulse();
        int n = cyc;
        model_reset();
        push_exp(n + 1);
        @(posedge clk);
        #2;
        rstb = 1'b0;
        push_exp(n + 2);
        @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    // Monitor: compares queued expectations against sampled outputs.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale_expectation cyc=%0d expected for cyc=%0d never compared",
                     cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (input_spike !== e.spk || all_idle !== e.idle || underrun !== e.und ||
                overrun !== e.ovr || in_ready !== e.rdy) begin
                errors++;
                $display("FAIL cycle_outputs cyc=%0d got spike=%b idle=%b und=%b ovr=%b rdy=%b want spike=%b idle=%b und=%b ovr=%b rdy=%b",
                         cyc, input_spike, all_idle, underrun, overrun, in_ready,
                         e.spk, e.idle, e.und, e.ovr, e.rdy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rstb     = 1'b0;
        grst     = 1'b0;
        in_valid = 1'b0;
        in_mask  = '0;
        in_times = '0;

        // Reset state
        run(2);
        rstb = 1'b1;
        run(1);

        // Word A: all lanes, times {0,1,5,7}
        in_valid = 1'b1;
        in_mask  = 4'b1111;
        in_times = pack(0, 1, 5, 7);
        tick();
        in_valid = 1'b0;
        tick();

        // Gamma 1; stage word B at k=2, then hold valid with word C while full
        grst = 1'b1;
        tick();
        grst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_mask  = 4'b0101;
        in_times = pack(3, 6, 0, 2);
        tick();
        in_mask  = 4'b1111;
        in_times = pack(0, 4, 2, 1);
        run(13);

        // Gamma 2 plays B; C is captured the cycle after grst
        grst = 1'b1;
        tick();
        grst = 1'b0;
        tick();
        in_valid = 1'b0;
        run(14);

        // Gamma 3 plays C; stage D, then abort at k=4 while lane 0 fires
        grst = 1'b1;
        tick();
        grst = 1'b0;
        tick();
        in_valid = 1'b1;
        in_mask  = 4'b1111;
        in_times = pack(1, 0, 2, 3);
        tick();
        in_valid = 1'b0;
        tick();
        grst = 1'b1;
        tick();
        grst = 1'b0;
        run(15);

        // Underrun with nothing offered: ready stays high
        grst = 1'b1;
        tick();
        grst = 1'b0;
        run(3);

        // Underrun with a same-edge handshake: word E staged for next gamma
        grst     = 1'b1;
        in_valid = 1'b1;
        in_mask  = 4'b1000;
        in_times = pack(0, 0, 0, 6);
        tick();
        grst     = 1'b0;
        in_valid = 1'b0;
        run(15);

        // Gamma plays E; reset asynchronously while lane 3 fires
        grst = 1'b1;
        tick();
        grst = 1'b0;
        run(7);
        async_reset_pulse();
        run(3);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
